// File: rtl/iir_sos_cascade_axis.sv
// Cascade of NUM_SOS direct-form-I biquads sharing one multiplier, AXI4-Stream in/out.
// Optional macro IIR_SAT_EN: saturate section outputs instead of two's-complement wrap.
module iir_sos_cascade_axis #(
  parameter int NUM_SOS = 4,
  parameter int INOUT_W = 16,
  parameter int COEFF_W = 25,
  parameter int SCALE   = 23,
  parameter int ADDR_W  = $clog2(NUM_SOS*5)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INOUT_W-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [INOUT_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  input  logic               coef_wr_en,
  input  logic [ADDR_W-1:0]  coef_wr_addr,
  input  logic [COEFF_W-1:0] coef_wr_data,
  input  logic               clear_state,
  output logic               busy
);

  localparam int NCOEF  = NUM_SOS*5;
  localparam int PROD_W = INOUT_W + COEFF_W;
  localparam int ACC_W  = PROD_W + 3;
  localparam int SEC_W  = (NUM_SOS > 1) ? $clog2(NUM_SOS) : 1;
  localparam logic [ADDR_W-1:0]         NCOEF_A  = ADDR_W'(NCOEF);
  localparam logic signed [COEFF_W-1:0] COEF_ONE = COEFF_W'(64'd1 << SCALE);

  // Valid/ready: a beat moves on any edge where valid && ready are both high;
  // the source holds data stable until then and the sink may drop ready freely.
  typedef enum logic [1:0] {IDLE, MAC, UPD, OUT} state_t;

  state_t                      state_q, state_d;
  logic [SEC_W-1:0]            sec_q, sec_d;
  logic [2:0]                  k_q, k_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [INOUT_W-1:0]   x_q, x_d;
  logic signed [INOUT_W-1:0]   tdata_q, tdata_d;

  logic signed [COEFF_W-1:0]   coef_q [NCOEF];
  logic signed [INOUT_W-1:0]   x1_q [NUM_SOS];
  logic signed [INOUT_W-1:0]   x2_q [NUM_SOS];
  logic signed [INOUT_W-1:0]   y1_q [NUM_SOS];
  logic signed [INOUT_W-1:0]   y2_q [NUM_SOS];

  logic                        coef_we, hist_clr, hist_upd;
  logic [ADDR_W-1:0]           coef_idx;
  logic signed [INOUT_W-1:0]   op;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     prod_ext, acc_base;
  logic signed [INOUT_W-1:0]   y_sec;

  assign coef_we  = coef_wr_en && (state_q == IDLE) && (coef_wr_addr < NCOEF_A);
  assign coef_idx = ADDR_W'(sec_q) * ADDR_W'(5) + ADDR_W'(k_q);

  // k walks b0*x, b1*x1, b2*x2, a1*y1, a2*y2; the feedback terms are subtracted.
  always_comb begin
    op = x_q;
    case (k_q)
      3'd1:    op = x1_q[sec_q];
      3'd2:    op = x2_q[sec_q];
      3'd3:    op = y1_q[sec_q];
      3'd4:    op = y2_q[sec_q];
      default: op = x_q;
    endcase
  end

  assign prod     = PROD_W'(op) * PROD_W'(coef_q[coef_idx]);
  assign prod_ext = ACC_W'(prod);
  assign acc_base = (k_q == 3'd0) ? '0 : acc_q;

`ifdef IIR_SAT_EN
  logic signed [ACC_W-1:0] y_full;
  assign y_full = acc_q >>> SCALE;
  always_comb begin
    y_sec = y_full[INOUT_W-1:0];
    if (y_full[ACC_W-1:INOUT_W-1] != {(ACC_W-INOUT_W+1){y_full[ACC_W-1]}})
      y_sec = {y_full[ACC_W-1], {(INOUT_W-1){~y_full[ACC_W-1]}}};
  end
`else
  assign y_sec = INOUT_W'(acc_q >>> SCALE);
`endif

  always_comb begin
    state_d       = state_q;
    sec_d         = sec_q;
    k_d           = k_q;
    acc_d         = acc_q;
    x_d           = x_q;
    tdata_d       = tdata_q;
    hist_clr      = 1'b0;
    hist_upd      = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state_q)
      IDLE: begin
        s_axis_tready = !clear_state;
        if (clear_state) begin
          hist_clr = 1'b1;
        end else if (s_axis_tvalid) begin
          x_d     = $signed(s_axis_tdata);
          sec_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = (k_q >= 3'd3) ? acc_base - prod_ext : acc_base + prod_ext;
        if (k_q == 3'd4) begin
          k_d     = '0;
          state_d = UPD;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      UPD: begin
        hist_upd = 1'b1;
        x_d      = y_sec;
        if (sec_q == SEC_W'(NUM_SOS-1)) begin
          tdata_d = y_sec;
          state_d = OUT;
        end else begin
          sec_d   = sec_q + SEC_W'(1);
          state_d = MAC;
        end
      end
      OUT: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sec_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      tdata_q <= '0;
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= (i % 5 == 0) ? COEF_ONE : '0;
      for (int s = 0; s < NUM_SOS; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      tdata_q <= tdata_d;
      if (coef_we) coef_q[coef_wr_addr] <= $signed(coef_wr_data);
      if (hist_clr) begin
        for (int s = 0; s < NUM_SOS; s++) begin
          x1_q[s] <= '0;
          x2_q[s] <= '0;
          y1_q[s] <= '0;
          y2_q[s] <= '0;
        end
      end else if (hist_upd) begin
        x2_q[sec_q] <= x1_q[sec_q];
        x1_q[sec_q] <= x_q;
        y2_q[sec_q] <= y1_q[sec_q];
        y1_q[sec_q] <= y_sec;
      end
    end
  end

  assign m_axis_tdata = tdata_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_iir_sos_cascade_axis.sv
// Directed bench for iir_sos_cascade_axis (default parameters, 4 sections, SCALE=23).
module tb_iir_sos_cascade_axis;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          coef_wr_en;
  logic [4:0]    coef_wr_addr;
  logic [24:0]   coef_wr_data;
  logic          clear_state;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int prev_acc = 0;
  logic [W-1:0] exp_q[$];

  iir_sos_cascade_axis dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .clear_state(clear_state), .busy(busy)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic coef_write(input int addr, input int data);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 5'(addr);
    coef_wr_data = 25'(data);
    tick();
    coef_wr_en   = 1'b0;
  endtask

  task automatic do_clear();
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
  endtask

  task automatic do_accept(input int x);
    int n = 0;
    while (s_axis_tready !== 1'b1 && n < 200) begin tick(); n++; end
    check("accept_ready", s_axis_tready, 1);
    s_axis_tdata  = W'(x);
    s_axis_tvalid = 1'b1;
    tick();
    prev_acc      = last_acc;
    last_acc      = cyc;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = W'($urandom_range(0, 65535));
    check("busy_after_accept", busy, 1);
    check("s_ready_low_busy", s_axis_tready, 0);
  endtask

  // Latency counts the accept clock as clock 1.
  task automatic get_out(output logic signed [W-1:0] yo, output int lo);
    int n = 0;
    while (m_axis_tvalid !== 1'b1 && n < 1000) begin tick(); n++; end
    check("out_valid", m_axis_tvalid, 1);
    lo = n + 1;
    yo = $signed(m_axis_tdata);
    if (m_axis_tready) begin
      tick();
      check("tvalid_falls", m_axis_tvalid, 0);
    end
  endtask

  task automatic send(input int x, output logic signed [W-1:0] yo, output int lo);
    do_accept(x);
    get_out(yo, lo);
  endtask

  initial begin
    logic signed [W-1:0] y;
    logic [W-1:0] e;
    int lat;
    int seen;
    int dec_exp[11] = '{-500, -250, -125, -63, -32, -16, -8, -4, -2, -1, -1};
    int ecg_in[5]   = '{32767, 0, 0, 0, 0};
    int ecg_exp[5]  = '{0, -1, -2, -3, -4};

    rst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; clear_state = 1'b0;
    tick(); tick(); tick();
    check("rst_s_ready", s_axis_tready, 1);
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_m_data", $signed(m_axis_tdata), 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Passthrough impulse, latency and back-to-back throughput
    send(32767, y, lat);
    check("pass_impulse", y, 32767);
    check("pass_latency0", lat, 25);
    send(0, y, lat);
    check("pass_zero", y, 0);
    check("pass_latency1", lat, 25);
    check("throughput", last_acc - prev_acc, 26);

    // Coefficient write in the accept cycle applies to that sample (b0 = 0.5)
    coef_wr_en = 1'b1; coef_wr_addr = 5'd0; coef_wr_data = 25'd4194304;
    s_axis_tdata = W'(1000); s_axis_tvalid = 1'b1;
    tick();
    coef_wr_en = 1'b0; s_axis_tvalid = 1'b0;
    check("same_cycle_busy", busy, 1);
    get_out(y, lat);
    check("same_cycle_write", y, 500);

    // Writes while busy are dropped
    do_accept(1000);
    tick(); tick();
    coef_write(0, 0);
    get_out(y, lat);
    check("busy_write_this", y, 500);
    send(2000, y, lat);
    check("busy_write_later", y, 1000);

    // Out-of-range address ignored
    coef_write(20, 0);
    send(600, y, lat);
    check("addr_oob", y, 300);

    // clear_state beats a simultaneous sample
    coef_write(3, -4194304);
    s_axis_tdata = W'(12345); s_axis_tvalid = 1'b1; clear_state = 1'b1;
    #1;
    check("clear_ready_low", s_axis_tready, 0);
    tick();
    s_axis_tvalid = 1'b0; clear_state = 1'b0;
    check("clear_no_accept", busy, 0);

    // y = 0.5x + 0.5y1: negative impulse decays with floor rounding to -1
    for (int i = 0; i < 11; i++) exp_q.push_back(W'(dec_exp[i]));
    for (int i = 0; i < 11; i++) begin
      send((i == 0) ? -1000 : 0, y, lat);
      e = exp_q.pop_front();
      check($sformatf("decay_%0d", i), y, $signed(e));
    end

    // Backpressure during OUT
    do_clear();
    m_axis_tready = 1'b0;
    do_accept(1000);
    get_out(y, lat);
    check("bp_first", y, 500);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("bp_valid", m_axis_tvalid, 1);
      check("bp_data", $signed(m_axis_tdata), 500);
      check("bp_s_ready", s_axis_tready, 0);
    end
    m_axis_tready = 1'b1;
    tick();
    check("bp_release", m_axis_tvalid, 0);
    send(0, y, lat);
    check("bp_next", y, 250);

    // ECG section 0 impulse, first outputs hand-computed
    coef_write(0, 111);
    coef_write(1, -223);
    coef_write(2, 111);
    coef_write(3, -15487989);
    coef_write(4, 7253728);
    do_clear();
    for (int i = 0; i < 5; i++) exp_q.push_back(W'(ecg_exp[i]));
    for (int i = 0; i < 5; i++) begin
      send(ecg_in[i], y, lat);
      e = exp_q.pop_front();
      check($sformatf("ecg_%0d", i), y, $signed(e));
    end

    // Gain 1.5 overflow: wrap or saturate
    coef_write(0, 12582912);
    coef_write(1, 0);
    coef_write(2, 0);
    coef_write(3, 0);
    coef_write(4, 0);
    do_clear();
    send(30000, y, lat);
`ifdef IIR_SAT_EN
    check("ovf_pos", y, 32767);
`else
    check("ovf_pos", y, -20536);
`endif
    send(-30000, y, lat);
`ifdef IIR_SAT_EN
    check("ovf_neg", y, -32768);
`else
    check("ovf_neg", y, 20536);
`endif

    // Reset mid-MAC discards the sample and restores passthrough
    do_accept(1000);
    tick(); tick();
    rst = 1'b1;
    #2;
    check("midrst_valid", m_axis_tvalid, 0);
    check("midrst_s_ready", s_axis_tready, 1);
    check("midrst_data", $signed(m_axis_tdata), 0);
    check("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_axis_tvalid === 1'b1) seen++;
    end
    check("midrst_no_output", seen, 0);
    send(32767, y, lat);
    check("midrst_pass", y, 32767);
    check("midrst_latency", lat, 25);
    send(0, y, lat);
    check("midrst_zero", y, 0);

    // clear in IDLE then impulse reproduces the passthrough response
    do_clear();
    send(32767, y, lat);
    check("clear_pass", y, 32767);
    check("clear_latency", lat, 25);
    send(0, y, lat);
    check("clear_zero", y, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
